// File: rtl/memory_param.sv
// Parameterised single-port word memory with registered read, a valid strobe and an optional zero-fill sweep.
// Define MEMORY_PARAM_CLEAR_EN to enable the CLEAR state (reset and the clear input zero-fill the array).
module memory_param #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             select,
    input  logic             rw,
    input  logic [AW-1:0]    address,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clear,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             ready,
    output logic             busy
);

    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_q, valid_d;
    logic             in_range;
    logic             accept;
    logic             sweep_we;
    logic [AW-1:0]    sweep_addr;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    assign in_range = ({1'b0, address} < DEPTH_W);

`ifdef MEMORY_PARAM_CLEAR_EN
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_e;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // clear is only sampled in IDLE, so a pulse during a sweep cannot restart it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (clear) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    assign ready      = (state_q == S_IDLE);
    assign busy       = (state_q == S_CLEAR);
    assign accept     = select && ready && !clear;
    assign sweep_we   = busy;
    assign sweep_addr = cnt_q;
`else
    logic unused_clear;

    assign ready        = 1'b1;
    assign busy         = 1'b0;
    assign accept       = select;
    assign sweep_we     = 1'b0;
    assign sweep_addr   = '0;
    assign unused_clear = clear;
`endif

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = address;
        wr_data = data_in;
        if (sweep_we) begin
            wr_en   = 1'b1;
            wr_addr = sweep_addr;
            wr_data = '0;
        end else if (accept && rw && in_range) begin
            wr_en = 1'b1;
        end
    end

    // Array has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        if (accept && !rw) begin
            valid_d    = 1'b1;
            data_out_d = in_range ? mem[address] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
        end
    end

    assign data_out = data_out_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_memory_param.sv
// Drives a DEPTH=8 and a DEPTH=5 instance with shared stimulus and compares both to an array-level model.
// Expectations follow MEMORY_PARAM_CLEAR_EN the same way the design does.
module tb_memory_param;

`ifdef MEMORY_PARAM_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       select  = 1'b0;
    logic       rw      = 1'b0;
    logic [2:0] address = '0;
    logic [7:0] data_in = '0;
    logic       clear   = 1'b0;

    logic [7:0] dout8, dout5;
    logic       valid8, ready8, busy8;
    logic       valid5, ready5, busy5;

    memory_param #(.WIDTH(8), .DEPTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .select(select), .rw(rw), .address(address),
        .data_in(data_in), .clear(clear), .data_out(dout8), .valid(valid8),
        .ready(ready8), .busy(busy8)
    );

    memory_param #(.WIDTH(8), .DEPTH(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .select(select), .rw(rw), .address(address),
        .data_in(data_in), .clear(clear), .data_out(dout5), .valid(valid5),
        .ready(ready5), .busy(busy5)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: index 0 is the DEPTH=8 instance, index 1 the DEPTH=5 instance.
    int         m_depth [2] = '{8, 5};
    logic [7:0] m_mem   [2][8];
    bit         m_known [2][8];
    int         m_busy  [2];
    logic [7:0] m_dout  [2];
    bit         m_dknown[2];
    bit         m_valid [2];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
        end
    endtask

    task automatic model_zero(input int i);
        for (int a = 0; a < m_depth[i]; a++) begin
            m_mem[i][a]   = '0;
            m_known[i][a] = 1'b1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_dout[i]   = '0;
            m_dknown[i] = 1'b1;
            m_valid[i]  = 1'b0;
            m_busy[i]   = 0;
            if (CLR_EN) begin
                m_busy[i] = m_depth[i];
                model_zero(i);
            end
        end
    endtask

    // One rising edge: a sweep is modelled as instant zero-fill plus DEPTH busy cycles.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0;
            if (m_busy[i] > 0) begin
                m_busy[i]--;
            end else if (CLR_EN && clear) begin
                m_busy[i] = m_depth[i];
                model_zero(i);
            end else if (select && rw) begin
                if (int'(address) < m_depth[i]) begin
                    m_mem[i][address]   = data_in;
                    m_known[i][address] = 1'b1;
                end
            end else if (select) begin
                m_valid[i] = 1'b1;
                if (int'(address) < m_depth[i]) begin
                    m_dout[i]   = m_mem[i][address];
                    m_dknown[i] = m_known[i][address];
                end else begin
                    m_dout[i]   = '0;
                    m_dknown[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_outs();
        for (int i = 0; i < 2; i++) begin
            string p;
            p = (i == 0) ? "d8" : "d5";
            chk({p, "_valid"}, (i == 0) ? 32'(valid8) : 32'(valid5), 32'(m_valid[i]));
            chk({p, "_busy"},  (i == 0) ? 32'(busy8)  : 32'(busy5),  32'(m_busy[i] > 0));
            chk({p, "_ready"}, (i == 0) ? 32'(ready8) : 32'(ready5), 32'(m_busy[i] == 0));
            if (m_dknown[i]) begin
                chk({p, "_dout"}, (i == 0) ? 32'(dout8) : 32'(dout5), 32'(m_dout[i]));
            end
        end
    endtask

    task automatic step(input bit s, input bit w, input logic [2:0] a,
                        input logic [7:0] d, input bit c);
        select  = s;
        rw      = w;
        address = a;
        data_in = d;
        clear   = c;
        @(posedge clk);
        model_edge();
        #1;
        check_outs();
        $display("t=%0t sel=%0b rw=%0b a=%0d d=%02h clr=%0b | d8 v=%0b q=%02h busy=%0b | d5 v=%0b q=%02h busy=%0b",
                 $time, s, w, a, d, c, valid8, dout8, busy8, valid5, dout5, busy5);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    endtask

    // Asserted mid-cycle so the immediate (asynchronous) effect is visible before any edge.
    task automatic do_reset();
        select = 1'b0;
        clear  = 1'b0;
        rst_n  = 1'b0;
        model_reset();
        #1;
        check_outs();
        $display("t=%0t reset asserted | d8 v=%0b q=%02h | d5 v=%0b q=%02h", $time, valid8, dout8, valid5, dout5);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        do_reset();
        idle(8);
        step(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);

        step(1'b1, 1'b1, 3'd0, 8'hAA, 1'b0);
        step(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);

        step(1'b1, 1'b1, 3'd1, 8'h11, 1'b0);
        step(1'b1, 1'b1, 3'd2, 8'h22, 1'b0);
        step(1'b1, 1'b1, 3'd3, 8'h33, 1'b0);
        for (int a = 1; a <= 3; a++) step(1'b1, 1'b0, 3'(a), 8'h00, 1'b0);
        idle(1);

        step(1'b1, 1'b1, 3'd6, 8'hFF, 1'b0);
        step(1'b1, 1'b0, 3'd6, 8'h00, 1'b0);
        for (int a = 0; a <= 4; a++) step(1'b1, 1'b0, 3'(a), 8'h00, 1'b0);

        step(1'b1, 1'b1, 3'd2, 8'h5A, 1'b0);
        step(1'b1, 1'b1, 3'd4, 8'hA5, 1'b1);
        idle(8);
        step(1'b1, 1'b0, 3'd2, 8'h00, 1'b0);
        step(1'b1, 1'b0, 3'd4, 8'h00, 1'b0);

        step(1'b1, 1'b1, 3'd2, 8'h5A, 1'b0);
        step(1'b1, 1'b0, 3'd2, 8'h00, 1'b0);
        do_reset();
        idle(9);
        step(1'b1, 1'b0, 3'd2, 8'h00, 1'b0);

        step(1'b1, 1'b1, 3'd5, 8'h3C, 1'b0);
        step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        idle(1);
        do_reset();
        idle(9);
        step(1'b1, 1'b0, 3'd5, 8'h00, 1'b0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                     3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 49) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_param.md
MEMORY_PARAM -- requirements
Module: memory_param

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL provide parameter DEPTH, default 8, number of words (>=2; need not be a power of two).
REQ-003 SHALL derive local AW = ceil(log2(DEPTH)) as the address width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port select  input  1  access request qualifier.
REQ-007 SHALL have port rw  input  1  1 = write, 0 = read.
REQ-008 SHALL have port address  input  AW  word address.
REQ-009 SHALL have port data_in  input  WIDTH  write data.
REQ-010 SHALL have port clear  input  1  soft-clear request pulse.
REQ-011 SHALL have port data_out  output  WIDTH  registered read data.
REQ-012 SHALL have port valid  output  1  one-cycle strobe marking new data_out.
REQ-013 SHALL have port ready  output  1  block accepts requests this cycle.
REQ-014 SHALL have port busy  output  1  clear sweep in progress.

Function
REQ-015 SHALL implement FSM with states CLEAR and IDLE; ready = (state == IDLE), busy = (state == CLEAR).
REQ-016 Request SHALL be accepted at a rising edge only when select=1 and ready=1; otherwise it is dropped, not queued.
REQ-017 Accepted write (rw=1) SHALL store data_in at address at that edge; valid stays 0; data_out unchanged.
REQ-018 Accepted read (rw=0) SHALL load data_out with mem[address] at that edge; valid=1 for exactly the following cycle; latency 1 cycle.
REQ-019 Back-to-back reads SHALL be sustained at one per cycle, valid held high across consecutive accepted reads.
REQ-020 Read one cycle after a write to the same address SHALL return the newly written data.
REQ-021 data_out SHALL hold its last value when no read is accepted.
REQ-022 Address >= DEPTH: write SHALL be ignored; read SHALL return all-zero data with valid=1.
REQ-023 CLEAR state SHALL write zero to addresses 0..DEPTH-1, one per cycle, using an AW-bit counter, then enter IDLE the cycle after address DEPTH-1 is written (sweep = DEPTH cycles).
REQ-024 clear=1 in IDLE SHALL enter CLEAR at the next edge, with counter = 0; clear takes priority over a simultaneous select request, which is dropped.
REQ-025 clear=1 during CLEAR SHALL be ignored (no restart).

Reset
REQ-026 rst_n=0 SHALL immediately force: data_out = 0, valid = 0, clear counter = 0, state = CLEAR (macro defined) or IDLE (macro undefined).
REQ-027 Memory array SHALL NOT be reset asynchronously; its contents are defined only via the clear sweep or writes.
REQ-028 Reset asserted mid-sweep or mid-read SHALL abort the operation; after release the sweep restarts from address 0 (macro defined).

Configuration
REQ-029 Macro MEMORY_PARAM_CLEAR_EN defined: reset enters CLEAR, clear input is honoured, zero-fill per REQ-023..025.
REQ-030 Macro MEMORY_PARAM_CLEAR_EN undefined: no CLEAR state or counter, reset enters IDLE, ready=1 from the first edge after release, busy tied 0, clear ignored, contents unspecified until written.

Verification
REQ-031 Reset with CLEAR_EN, DEPTH=8: busy=1, ready=0 for 8 cycles after rst_n rises; then read address 000 -> data_out=00000000, valid=1 one cycle later.
REQ-032 Write 10101010 to address 000, read it on the next cycle -> data_out=10101010 one cycle after the read; write cycle shows valid=0.
REQ-033 Write 0x11, 0x22, 0x33 to addresses 1, 2, 3, then 3 consecutive reads -> valid high 3 consecutive cycles with data 0x11, 0x22, 0x33.
REQ-034 WIDTH=8, DEPTH=5: write 0xFF to address 6, read address 6 -> data_out=0x00, valid=1; addresses 0-4 unaffected.
REQ-035 Write 0x5A to address 2, pulse clear together with a write of 0xA5 to address 4 -> write dropped, busy=1 for DEPTH cycles; reads of addresses 2 and 4 return 0x00.
REQ-036 Assert rst_n=0 in the 3rd sweep cycle -> outputs zero immediately; after release busy lasts a full DEPTH cycles. Without CLEAR_EN, ready=1 on the first edge after release and clear has no effect.
